// File: rtl/ctx_data_mux.sv
// ---------------------------------------------------------------------------
// ctx_data_mux
//
// Registered N-way data selector between the per-context cache banks and the
// CPU read-data path. One channel is active at a time (cur_sel). Only that
// channel can hand over words, through a valid/ready handshake, into a single
// output register. The active channel changes only through a sw_req/sw_ack
// handshake. That handshake first drains the output register, so words from
// two channels are never mixed.
//
// Parameters
//   WIDTH        data word width
//   CHANNELS     number of input channels (2..32)
//   DEFAULT_SEL  channel active after reset (< CHANNELS)
//
// Ports
//   clock      sole clock, rising edge
//   reset_n    synchronous reset, active low
//   in_data    flattened channel words, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (at most one bit high)
//   out_data   registered output word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data
//   sw_req     switch request, honoured only while idle
//   sw_sel     target channel for sw_req
//   sw_ack     one-cycle pulse while the switch commits
//   sw_err     one-cycle pulse after a request for a nonexistent channel
//   busy       a switch is in progress
//   cur_sel    currently active channel
//   sw_count   (only with CTX_DATA_MUX_SWCNT_EN) saturating count of
//              committed switches
//
// Build option: define CTX_DATA_MUX_SWCNT_EN to add the sw_count port.
// ---------------------------------------------------------------------------
module ctx_data_mux #(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 12,
  parameter int DEFAULT_SEL = 6
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          sw_req,
  input  logic [$clog2(CHANNELS)-1:0]   sw_sel,
  output logic                          sw_ack,
  output logic                          sw_err,
  output logic                          busy,
  output logic [$clog2(CHANNELS)-1:0]   cur_sel
`ifdef CTX_DATA_MUX_SWCNT_EN
  ,
  output logic [15:0]                   sw_count
`endif
);

  localparam int              SEL_W   = $clog2(CHANNELS);
  // One extra bit so that the channel count itself is representable.
  localparam logic [SEL_W:0]  CH_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  logic [1:0]          state_r;
  logic [SEL_W-1:0]    cur_sel_r;
  logic [SEL_W-1:0]    pend_sel_r;
  logic [WIDTH-1:0]    out_data_r;
  logic                out_valid_r;
  logic                sw_ack_r;
  logic                sw_err_r;
  logic                busy_r;

  logic                out_free_s;
  logic                accept_s;
  logic                sel_valid_s;
  logic [WIDTH-1:0]    sel_word_s;
  logic [CHANNELS-1:0] in_ready_s;
  logic                transfer_s;
  logic                sel_ok_s;

  // Output register can take a new word this cycle (empty or being consumed).
  assign out_free_s = !out_valid_r || out_ready;
  // Reset is folded in so that in_ready stays low while reset_n is low.
  assign accept_s   = reset_n && (state_r == ST_IDLE) && out_free_s;
  assign transfer_s = accept_s && sel_valid_s;
  assign sel_ok_s   = ({1'b0, sw_sel} < CH_LIM);

  // AND-OR select of the active channel. cur_sel never exceeds CHANNELS-1,
  // so exactly one term is enabled.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_word_s  = {WIDTH{1'b0}};
    in_ready_s  = {CHANNELS{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      sel_valid_s   = sel_valid_s | (in_valid[k] & (cur_sel_r == SEL_W'(k)));
      sel_word_s    = sel_word_s | (in_data[k*WIDTH +: WIDTH] & {WIDTH{cur_sel_r == SEL_W'(k)}});
      in_ready_s[k] = accept_s && (cur_sel_r == SEL_W'(k));
    end
  end

  // Output word register: load on transfer, release on consumption.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (transfer_s) begin
      out_data_r  <= sel_word_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Switch FSM: IDLE -> DRAIN (until output is free) -> SWITCH -> IDLE.
  // ack and busy are registered alongside the state so they are glitch-free.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cur_sel_r  <= DEF_SEL;
      pend_sel_r <= DEF_SEL;
      sw_ack_r   <= 1'b0;
      sw_err_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      sw_ack_r <= 1'b0;
      sw_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sw_req) begin
            if (sel_ok_s) begin
              pend_sel_r <= sw_sel;
              state_r    <= ST_DRAIN;
              busy_r     <= 1'b1;
            end else begin
              sw_err_r <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The word still held is consumed in this same cycle.
          if (out_free_s) begin
            state_r  <= ST_SWITCH;
            sw_ack_r <= 1'b1;
          end
        end
        ST_SWITCH: begin
          cur_sel_r <= pend_sel_r;
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CTX_DATA_MUX_SWCNT_EN
  logic [15:0] sw_count_r;

  // Saturating count of committed switches. Rejected requests never reach
  // SWITCH, so they are not counted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sw_count_r <= 16'h0000;
    end else if ((state_r == ST_SWITCH) && (sw_count_r != 16'hFFFF)) begin
      sw_count_r <= sw_count_r + 16'd1;
    end
  end

  assign sw_count = sw_count_r;
`else
  // Switch counter not built in this configuration.
`endif

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign sw_ack    = sw_ack_r;
  assign sw_err    = sw_err_r;
  assign busy      = busy_r;
  assign cur_sel   = cur_sel_r;

endmodule

// File: tb/tb_ctx_data_mux.sv
// Self-checking bench for ctx_data_mux (WIDTH=32, CHANNELS=12, DEFAULT_SEL=6).
// The reference model describes the mux as an active channel, a one-word
// output slot and a switch in progress (draining / committing).
module tb_ctx_data_mux;
  localparam int WIDTH = 32;
  localparam int CHANNELS = 12;
  localparam int DEFAULT_SEL = 6;
  localparam int SEL_W = 4;

  logic                      clock;
  logic                      reset_n;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sw_req;
  logic [SEL_W-1:0]          sw_sel;
  logic                      sw_ack;
  logic                      sw_err;
  logic                      busy;
  logic [SEL_W-1:0]          cur_sel;
`ifdef CTX_DATA_MUX_SWCNT_EN
  logic [15:0]               sw_count;
`endif

  ctx_data_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEFAULT_SEL(DEFAULT_SEL)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sw_req(sw_req), .sw_sel(sw_sel), .sw_ack(sw_ack),
    .sw_err(sw_err), .busy(busy), .cur_sel(cur_sel)
`ifdef CTX_DATA_MUX_SWCNT_EN
    , .sw_count(sw_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SEL_W-1:0]    m_sel = 4'd6;
  logic [SEL_W-1:0]    m_pend = 4'd6;
  bit                  m_full = 1'b0;
  logic [WIDTH-1:0]    m_word = 32'h0;
  bit                  m_draining = 1'b0;
  bit                  m_committing = 1'b0;
  bit                  m_ack = 1'b0;
  bit                  m_err = 1'b0;
  logic [15:0]         m_cnt = 16'h0;
  logic [CHANNELS-1:0] pre_ready;
  logic [CHANNELS-1:0] exp_pre_ready;

  function automatic logic [CHANNELS-1:0] model_ready();
    logic [CHANNELS-1:0] r;
    r = 12'h000;
    if (reset_n && !m_draining && !m_committing && (!m_full || out_ready))
      r[m_sel] = 1'b1;
    return r;
  endfunction

  // What one rising edge does to the model, given the current inputs.
  task automatic model_clock();
    bit was_full;
    bit take;
    if (!reset_n) begin
      m_sel = 4'(DEFAULT_SEL); m_pend = 4'(DEFAULT_SEL); m_full = 1'b0; m_word = 32'h0;
      m_draining = 1'b0; m_committing = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_cnt = 16'h0;
    end else begin
      was_full = m_full;
      take = !m_draining && !m_committing && (!was_full || out_ready) && in_valid[m_sel];
      m_ack = 1'b0;
      m_err = 1'b0;
      if (take) begin
        m_word = in_data[int'(m_sel)*WIDTH +: WIDTH];
        m_full = 1'b1;
      end else if (was_full && out_ready) begin
        m_full = 1'b0;
      end
      if (m_committing) begin
        m_sel = m_pend;
        m_committing = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (m_draining) begin
        if (!was_full || out_ready) begin
          m_draining = 1'b0;
          m_committing = 1'b1;
          m_ack = 1'b1;
        end
      end else if (sw_req) begin
        if (int'(sw_sel) < CHANNELS) begin
          m_pend = sw_sel;
          m_draining = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  // Apply current inputs for one cycle: sample in_ready before the edge, then
  // advance the model and leave time 1 unit after the edge for sampling.
  task automatic cycle();
    #1;
    pre_ready = in_ready;
    exp_pre_ready = model_ready();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < CHANNELS; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
  endtask

  task automatic set_word(input int k, input logic [WIDTH-1:0] w);
    in_data[k*WIDTH +: WIDTH] = w;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 12'hFFF; out_ready = 1'b1; sw_req = 1'b1; sw_sel = 4'd2;
    randomize_data();
    repeat (3) cycle();
    checks++; if (pre_ready !== 12'h000) begin errors++; $display("FAIL rst_in_ready got %h exp 000", pre_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if (cur_sel !== 4'd6) begin errors++; $display("FAIL rst_cur_sel got %0d exp 6", cur_sel); end
    checks++; if ({busy, sw_ack, sw_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {busy, sw_ack, sw_err}); end
    reset_n = 1'b1; sw_req = 1'b0; in_valid = 12'h040; set_word(6, 32'hA5A5_0006);
    cycle();
    checks++; if (pre_ready !== 12'h040) begin errors++; $display("FAIL rel_in_ready got %h exp 040", pre_ready); end
    checks++; if (out_data !== 32'hA5A5_0006 || out_valid !== 1'b1) begin errors++; $display("FAIL rel_first_word got %h/%b exp a5a50006/1", out_data, out_valid); end
    in_valid = 12'h000;
    cycle();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 12'hFFF;
    for (int i = 1; i <= 8; i++) begin
      randomize_data();
      set_word(6, 32'(i));
      cycle();
      checks++; if (pre_ready !== 12'h040) begin errors++; $display("FAIL stream_ready[%0d] got %h exp 040", i, pre_ready); end
      checks++; if (out_data !== 32'(i) || out_valid !== 1'b1) begin errors++; $display("FAIL stream_word[%0d] got %h/%b exp %h/1", i, out_data, out_valid, i); end
    end
    in_valid = 12'h000;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %b exp 0", out_valid); end
  endtask

  task automatic test_switch_stall();
    in_valid = 12'h040; set_word(6, 32'h600D_0001); out_ready = 1'b0;
    cycle();
    in_valid = 12'hFFF; randomize_data(); sw_req = 1'b1; sw_sel = 4'd2;
    cycle();  // t -> t+1 (DRAIN)
    sw_req = 1'b0;
    checks++; if (busy !== 1'b1 || sw_ack !== 1'b0 || cur_sel !== 4'd6) begin errors++; $display("FAIL stall_drain got busy=%b ack=%b sel=%0d exp 1/0/6", busy, sw_ack, cur_sel); end
    checks++; if (out_data !== 32'h600D_0001 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%b exp 600d0001/1", out_data, out_valid); end
    repeat (2) begin
      cycle();
      checks++; if (pre_ready !== 12'h000) begin errors++; $display("FAIL stall_ready got %h exp 000", pre_ready); end
      checks++; if (busy !== 1'b1 || sw_ack !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_wait got busy=%b ack=%b ov=%b exp 1/0/1", busy, sw_ack, out_valid); end
    end
    out_ready = 1'b1;  // t+3
    cycle();
    checks++; if (pre_ready !== 12'h000) begin errors++; $display("FAIL stall_ready_t3 got %h exp 000", pre_ready); end
    checks++; if (sw_ack !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_switch got ack=%b busy=%b ov=%b exp 1/1/0", sw_ack, busy, out_valid); end
    cycle();  // t+4 -> t+5
    checks++; if (cur_sel !== 4'd2 || busy !== 1'b0 || sw_ack !== 1'b0) begin errors++; $display("FAIL stall_commit got sel=%0d busy=%b ack=%b exp 2/0/0", cur_sel, busy, sw_ack); end
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      set_word(2, 32'hC2C2_0000 + 32'(i));
      cycle();
      checks++; if (pre_ready !== 12'h004) begin errors++; $display("FAIL ch2_ready[%0d] got %h exp 004", i, pre_ready); end
      checks++; if (out_data !== 32'hC2C2_0000 + 32'(i)) begin errors++; $display("FAIL ch2_word[%0d] got %h exp %h", i, out_data, 32'hC2C2_0000 + 32'(i)); end
    end
    in_valid = 12'h000;
    cycle();
  endtask

  task automatic test_invalid_sel();
    out_ready = 1'b1; in_valid = 12'h004;
    set_word(2, 32'h0BAD_0000);
    cycle();
    set_word(2, 32'h0BAD_0001); sw_req = 1'b1; sw_sel = 4'd13;
    cycle();
    sw_req = 1'b0;
    checks++; if (sw_err !== 1'b1 || busy !== 1'b0 || cur_sel !== 4'd2) begin errors++; $display("FAIL inv_err got err=%b busy=%b sel=%0d exp 1/0/2", sw_err, busy, cur_sel); end
    checks++; if (out_data !== 32'h0BAD_0001 || out_valid !== 1'b1) begin errors++; $display("FAIL inv_flow got %h/%b exp 0bad0001/1", out_data, out_valid); end
    set_word(2, 32'h0BAD_0002);
    cycle();
    checks++; if (sw_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL inv_pulse got err=%b busy=%b exp 0/0", sw_err, busy); end
    checks++; if (pre_ready !== 12'h004 || out_data !== 32'h0BAD_0002) begin errors++; $display("FAIL inv_stream got %h/%h exp 004/0bad0002", pre_ready, out_data); end
    in_valid = 12'h000;
    cycle();
  endtask

  task automatic test_ignored_and_reset();
    int acks;
    acks = 0;
    out_ready = 1'b1; in_valid = 12'h000; sw_req = 1'b1; sw_sel = 4'd5;
    cycle(); acks += int'(sw_ack);
    sw_sel = 4'd9;  // request pulsed while draining
    cycle(); acks += int'(sw_ack);
    sw_req = 1'b0;
    repeat (4) begin cycle(); acks += int'(sw_ack); end
    checks++; if (acks != 1) begin errors++; $display("FAIL ign_acks got %0d exp 1", acks); end
    checks++; if (cur_sel !== 4'd5 || busy !== 1'b0) begin errors++; $display("FAIL ign_sel got %0d/%b exp 5/0", cur_sel, busy); end
    // Transfer in the same cycle as the request, then reset during SWITCH.
    in_valid = 12'h020; set_word(5, 32'h5555_AAAA); out_ready = 1'b0; sw_req = 1'b1; sw_sel = 4'd3;
    cycle();
    sw_req = 1'b0; in_valid = 12'h000;
    checks++; if (out_data !== 32'h5555_AAAA || out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL req_xfer got %h/%b/%b exp 5555aaaa/1/1", out_data, out_valid, busy); end
    out_ready = 1'b1;
    cycle();
    checks++; if (sw_ack !== 1'b1) begin errors++; $display("FAIL mid_ack got %b exp 1", sw_ack); end
    reset_n = 1'b0;
    cycle();
    checks++; if (cur_sel !== 4'd6 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got sel=%0d ov=%b busy=%b exp 6/0/0", cur_sel, out_valid, busy); end
    reset_n = 1'b1;
    cycle();
    checks++; if (cur_sel !== 4'd6) begin errors++; $display("FAIL mid_discard got %0d exp 6", cur_sel); end
  endtask

`ifdef CTX_DATA_MUX_SWCNT_EN
  task automatic test_swcnt();
    logic [SEL_W-1:0] sels [4];
    sels = '{4'd1, 4'd7, 4'd14, 4'd11};
    reset_n = 1'b0; in_valid = 12'h000; out_ready = 1'b1; sw_req = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    foreach (sels[i]) begin
      sw_req = 1'b1; sw_sel = sels[i];
      cycle();
      sw_req = 1'b0;
      repeat (3) cycle();
    end
    checks++; if (sw_count !== 16'd3) begin errors++; $display("FAIL swcnt got %0d exp 3", sw_count); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      in_valid  = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sw_req    = ($urandom_range(0, 7) == 0);
      sw_sel    = 4'($urandom_range(0, 15));
      randomize_data();
      cycle();
      checks++; if (pre_ready !== exp_pre_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %h exp %h", n, pre_ready, exp_pre_ready); end
      checks++; if (out_valid !== m_full || out_data !== m_word) begin errors++; $display("FAIL rnd_out[%0d] got %h/%b exp %h/%b", n, out_data, out_valid, m_word, m_full); end
      checks++; if (cur_sel !== m_sel) begin errors++; $display("FAIL rnd_sel[%0d] got %0d exp %0d", n, cur_sel, m_sel); end
      checks++; if (busy !== (m_draining || m_committing) || sw_ack !== m_ack || sw_err !== m_err) begin
        errors++; $display("FAIL rnd_flags[%0d] got busy=%b ack=%b err=%b exp %b/%b/%b", n, busy, sw_ack, sw_err, m_draining || m_committing, m_ack, m_err);
      end
`ifdef CTX_DATA_MUX_SWCNT_EN
      checks++; if (sw_count !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", n, sw_count, m_cnt); end
`endif
    end
  endtask

  initial begin
    reset_n = 1'b0; in_data = '0; in_valid = 12'h000; out_ready = 1'b1;
    sw_req = 1'b0; sw_sel = 4'd0;
    test_reset();
    test_streaming();
    test_switch_stall();
    test_invalid_sel();
    test_ignored_and_reset();
`ifdef CTX_DATA_MUX_SWCNT_EN
    test_swcnt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctx_data_mux.md
# ctx_data_mux

Parametrised, registered N-way data selector that routes one of `CHANNELS` cache-side data streams to a single consumer, with a valid/ready handshake per channel. The active channel is changed only through a request/acknowledge switch handshake that drains the output register first, so a context switch never mixes words from two channels. It sits between the per-context cache banks and the CPU read-data path, and is driven by the context-switch controller.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits.
- `CHANNELS`, 12: number of input channels, 2..32.
- `DEFAULT_SEL`, 6: channel selected after reset; must be < `CHANNELS`.
- `SEL_W` is a localparam equal to `$clog2(CHANNELS)`; it is not overridable.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clock`, in, 1: sole clock; all state updates on its rising edge.
- `reset_n`, in, 1: synchronous reset, active low.
- `in_data`, in, `CHANNELS*WIDTH`: flattened inputs; channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `in_valid`, in, `CHANNELS`: per-channel valid.
- `in_ready`, out, `CHANNELS`: per-channel ready; at most one bit is high.
- `out_data`, out, `WIDTH`: registered output word.
- `out_valid`, out, 1: `out_data` holds an unconsumed word.
- `out_ready`, in, 1: consumer accepts `out_data`.
- `sw_req`, in, 1: request to switch the active channel; sampled only in IDLE.
- `sw_sel`, in, `SEL_W`: target channel; sampled together with `sw_req`.
- `sw_ack`, out, 1: one-cycle pulse when the switch is committed.
- `sw_err`, out, 1: one-cycle pulse when `sw_sel >= CHANNELS`.
- `busy`, out, 1: a switch is in progress.
- `cur_sel`, out, `SEL_W`: currently active channel.

## Operation
- The FSM has three states: IDLE, DRAIN and SWITCH.
- **Channel acceptance:** `in_ready[k] = (state==IDLE) && (k==cur_sel) && (!out_valid || out_ready)`. All other `in_ready` bits are 0.
- **Transfer:** a transfer occurs when `in_valid[cur_sel] && in_ready[cur_sel]`. On a transfer, `out_data` is loaded with the channel word and `out_valid` is set.
- **Consumption:** when `out_valid && out_ready` and no new transfer occurs in that cycle, `out_valid` is cleared. `out_data` holds its last value.
- **IDLE, valid request:** `sw_req` with `sw_sel < CHANNELS` latches `sw_sel` into the pending register and moves to DRAIN.
- **IDLE, invalid request:** `sw_req` with `sw_sel >= CHANNELS` produces an `sw_err` pulse on the next cycle. The FSM stays in IDLE, `cur_sel` is unchanged and the data flow is uninterrupted.
- **IDLE, request with transfer:** a transfer in the same cycle as `sw_req` completes normally.
- **DRAIN:** all `in_ready` bits are 0. The FSM moves to SWITCH in the cycle where `!out_valid || out_ready`; in that cycle the output word is consumed.
- **SWITCH:** `sw_ack` is 1 for this single cycle. `cur_sel` takes the pending value at the end of the cycle, and the FSM returns to IDLE.
- **`busy`:** high exactly when the FSM is in DRAIN or SWITCH.
- **`sw_req` while busy:** ignored and not queued.
- **Switch to the already-active channel:** the full handshake is still performed.
- **`in_valid` on non-selected channels:** ignored; it never produces `in_ready`.

## Timing
- **Reset values:** `out_valid` = 0, `out_data` = 0, `cur_sel` = `DEFAULT_SEL`, FSM = IDLE, `sw_ack` = 0, `sw_err` = 0, `busy` = 0, `in_ready` = 0 while `reset_n` is low.
- **Data latency:** 1 cycle from a transfer to `out_valid`. Sustained throughput is 1 word/cycle when `out_ready` is held high.
- **Switch latency, empty output:** with `sw_req` at cycle t, the FSM is in DRAIN at t+1, SWITCH (`sw_ack` = 1) at t+2, and the new `cur_sel` and IDLE at t+3.
- **Switch latency, occupied output:** each cycle `out_valid && !out_ready` persists adds one cycle in DRAIN.
- **Reset mid-switch:** `reset_n` low in DRAIN or SWITCH aborts the switch. The pending select is discarded and `cur_sel` returns to `DEFAULT_SEL`.

## Configuration
- **With `CTX_DATA_MUX_SWCNT_EN` defined:** adds the output port `sw_count`, 16 bits. It is reset to 0 and incremented in every SWITCH cycle. It saturates at 16'hFFFF and is not incremented by `sw_err` events.
- **Without the macro:** the port and its counter are absent, and behaviour is otherwise identical.

## Test plan
- **Reset defaults:** release reset with `CHANNELS`=12 and `in_valid[6]`=1 and `in_data` ch6=32'hA5A5_0006. Required: `cur_sel`=6, `in_ready`=12'h040, and `out_data`=32'hA5A5_0006 with `out_valid`=1 one cycle later.
- **Streaming:** drive ch6 with words 1..8 back-to-back and `out_ready`=1. Required: 8 words out in order on consecutive cycles and no `in_ready` on other channels.
- **Switch with stall:** `out_valid`=1 and `out_ready`=0, then `sw_req` with `sw_sel`=2 at t. Required: DRAIN holds and `in_ready`=0; `out_ready`=1 at t+3 moves to SWITCH at t+4 with `sw_ack`=1; `cur_sel`=2 at t+5; subsequent data comes from ch2 only.
- **Invalid select:** `sw_sel`=13 with `CHANNELS`=12. Required: `sw_err`=1 for one cycle, `busy` stays 0, `cur_sel` unchanged, streaming uninterrupted.
- **Ignored request and mid-switch reset:** `sw_req`=1 pulsed during DRAIN. Required: ignored and exactly one `sw_ack`. Then assert `reset_n`=0 during SWITCH. Required: `cur_sel`=6 and `out_valid`=0.
- **Switch counter (with `CTX_DATA_MUX_SWCNT_EN`):** 3 valid switches and 1 invalid switch. Required: `sw_count`=3.
